// File: rtl/cmos_pkg.sv
// Shared types and default geometry for the DVP camera capture path.
package cmos_pkg;

  localparam int CMOS_COL = 800;
  localparam int CMOS_ROW = 480;

  typedef logic [15:0] rgb565_t;

  typedef enum logic [1:0] {
    S_SYNC,
    S_VBLANK,
    S_ACTIVE
  } cmos_state_t;

endpackage

// File: rtl/cmos_capture_if.sv
// Camera pin bundle plus the pixel/frame output bus of cmos_capture.
interface cmos_capture_if
  import cmos_pkg::*;
#(
  parameter int COL = CMOS_COL,
  parameter int ROW = CMOS_ROW
);

  logic                   cmos_vsyn;
  logic                   cmos_href;
  logic [7:0]             cmos_data;
  rgb565_t                pix_data;
  logic                   pix_valid;
  logic [$clog2(COL)-1:0] pix_col;
  logic [$clog2(ROW)-1:0] pix_row;
  logic                   frame_start;
  logic                   frame_done;
  logic [15:0]            frame_cnt;
  logic                   err_line;
  logic                   err_frame;

  modport master (
    input  cmos_vsyn, cmos_href, cmos_data,
    output pix_data, pix_valid, pix_col, pix_row,
           frame_start, frame_done, frame_cnt, err_line, err_frame
  );

  modport slave (
    output cmos_vsyn, cmos_href, cmos_data,
    input  pix_data, pix_valid, pix_col, pix_row,
           frame_start, frame_done, frame_cnt, err_line, err_frame
  );

endinterface

// File: rtl/cmos_byte_pack.sv
// Pairs consecutive camera bytes (high first) into RGB565 words.
module cmos_byte_pack
  import cmos_pkg::*;
(
  input  logic       cmos_pclk,
  input  logic       RST,
  input  logic       en,
  input  logic       clr,
  input  logic [7:0] din,
  output logic       pix_stb,
  output rgb565_t    pix_word,
  output logic       dangling
);

  logic       phase;
  logic [7:0] hi;

  always_ff @(posedge cmos_pclk or posedge RST) begin
    if (RST) begin
      phase <= 1'b0;
      hi    <= '0;
    end else if (clr) begin
      phase <= 1'b0;
    end else if (en) begin
      if (!phase) hi <= din;
      phase <= ~phase;
    end
  end

  assign pix_stb  = en & phase;
  assign pix_word = {hi, din};
  // A clear while the high byte is still waiting means the line ended on an odd byte.
  assign dangling = clr & phase;

endmodule

// File: rtl/cmos_capture.sv
// DVP receiver: frame sync FSM, pixel/line/frame counters and geometry error checks.
module cmos_capture
  import cmos_pkg::*;
#(
  parameter int COL         = CMOS_COL,
  parameter int ROW         = CMOS_ROW,
  parameter int SKIP_FRAMES = 2
) (
  input  logic           cmos_pclk,
  input  logic           RST,
  cmos_capture_if.master bus
);

  localparam int COL_W = $clog2(COL);
  localparam int ROW_W = $clog2(ROW);
  // Counters are one bit wider than needed and saturate, so overlong lines/frames never alias.
  localparam int CW = $clog2(COL + 1) + 1;
  localparam int RW = $clog2(ROW + 1) + 1;
  localparam logic [CW-1:0] COL_V  = CW'(COL);
  localparam logic [RW-1:0] ROW_V  = RW'(ROW);
  localparam logic [15:0]   SKIP_V = 16'(SKIP_FRAMES);

  cmos_state_t      state;
  logic             vsyn_r, vsyn_rr, href_r;
  logic [7:0]       data_r;
  logic [CW-1:0]    col;
  logic [RW-1:0]    row;
  logic             line_act, frame_out, settled;
  rgb565_t          pix_data_q;
  logic             pix_valid_q, frame_start_q, frame_done_q, err_line_q, err_frame_q;
  logic [COL_W-1:0] pix_col_q;
  logic [ROW_W-1:0] pix_row_q;
  logic [15:0]      frame_cnt_q;

  logic    vsyn_rise, vsyn_fall, active, frame_end, byte_en, line_end, bp_clr;
  logic    skip_ok, accept, pix_stb, dangling;
  rgb565_t pix_word;

  assign vsyn_rise = vsyn_r & ~vsyn_rr;
  assign vsyn_fall = ~vsyn_r & vsyn_rr;
  assign active    = (state == S_ACTIVE);
  assign frame_end = active & vsyn_rise;
  assign byte_en   = active & href_r & ~vsyn_r;
  assign line_end  = active & line_act & ~href_r & ~vsyn_r;
  assign bp_clr    = line_end | frame_end | ((state == S_VBLANK) & vsyn_fall);
  // Sticky once reached, so the 16-bit frame counter wrapping never re-enters the skip window.
  assign skip_ok   = settled | (frame_cnt_q >= SKIP_V);
  assign accept    = skip_ok & (col < COL_V) & (row < ROW_V);

  cmos_byte_pack u_pack (
    .cmos_pclk (cmos_pclk),
    .RST       (RST),
    .en        (byte_en),
    .clr       (bp_clr),
    .din       (data_r),
    .pix_stb   (pix_stb),
    .pix_word  (pix_word),
    .dangling  (dangling)
  );

  always_ff @(posedge cmos_pclk or posedge RST) begin
    if (RST) begin
      state         <= S_SYNC;
      vsyn_r        <= 1'b0;
      vsyn_rr       <= 1'b0;
      href_r        <= 1'b0;
      data_r        <= '0;
      col           <= '0;
      row           <= '0;
      line_act      <= 1'b0;
      frame_out     <= 1'b0;
      settled       <= 1'b0;
      pix_data_q    <= '0;
      pix_valid_q   <= 1'b0;
      pix_col_q     <= '0;
      pix_row_q     <= '0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_cnt_q   <= '0;
      err_line_q    <= 1'b0;
      err_frame_q   <= 1'b0;
    end else begin
      vsyn_r        <= bus.cmos_vsyn;
      vsyn_rr       <= vsyn_r;
      href_r        <= bus.cmos_href;
      data_r        <= bus.cmos_data;
      settled       <= skip_ok;
      pix_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      err_frame_q   <= 1'b0;

      case (state)
        S_SYNC: begin
          if (vsyn_r) state <= S_VBLANK;
        end
        S_VBLANK: begin
          if (vsyn_fall) begin
            row       <= '0;
            col       <= '0;
            line_act  <= 1'b0;
            frame_out <= 1'b0;
            state     <= S_ACTIVE;
          end
        end
        S_ACTIVE: begin
          if (vsyn_rise) begin
            frame_cnt_q  <= frame_cnt_q + 16'd1;
            frame_done_q <= frame_out;
            err_frame_q  <= frame_out & (row != ROW_V);
            line_act     <= 1'b0;
            state        <= S_VBLANK;
          end else if (byte_en) begin
            line_act <= 1'b1;
            if (pix_stb) begin
              if (accept) begin
                pix_data_q    <= pix_word;
                pix_valid_q   <= 1'b1;
                pix_col_q     <= col[COL_W-1:0];
                pix_row_q     <= row[ROW_W-1:0];
                frame_start_q <= ~frame_out;
                frame_out     <= 1'b1;
                if (!frame_out) err_line_q <= 1'b0;
              end
              col <= (col == '1) ? col : col + CW'(1);
            end
          end else if (line_end) begin
            if (dangling || (col != COL_V)) err_line_q <= 1'b1;
            row      <= (row == '1) ? row : row + RW'(1);
            col      <= '0;
            line_act <= 1'b0;
          end
        end
        default: state <= S_SYNC;
      endcase
    end
  end

  assign bus.pix_data    = pix_data_q;
  assign bus.pix_valid   = pix_valid_q;
  assign bus.pix_col     = pix_col_q;
  assign bus.pix_row     = pix_row_q;
  assign bus.frame_start = frame_start_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.frame_cnt   = frame_cnt_q;
  assign bus.err_line    = err_line_q;
  assign bus.err_frame   = err_frame_q;

endmodule
